// File: rtl/nmix_mac_ctrl.sv
// nmix_mac_ctrl -- message sequencer and chaining stage around the bit-serial
// nmix mixer. Message words arrive on a valid/ready port. Each word is mixed
// with the running chaining value H (X = word, R = H), and the result is
// folded back with H <= H ^ Y. After the last word, H leaves on the tag port.
// If nmix never drops its dirty flag, a 10-bit watchdog aborts the message
// and reports an error tag.

module nmix_mac_ctrl #(
  parameter logic [31:0] IV      = 32'h0000_0000,  // initial chaining constant
  parameter int unsigned TIMEOUT = 1023             // max BUSY cycles before abort
) (
  input  logic        clk,
  input  logic        reset,       // asynchronous, active-low

  // upstream message port
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic [31:0] key,

  // downstream tag port
  output logic        tag_valid,
  input  logic        tag_ready,
  output logic [31:0] tag,
  output logic        tag_err,

  // nmix side
  output logic [31:0] nm_x,
  output logic [31:0] nm_r,
  output logic        nm_start,
  input  logic [31:0] nm_y,
  input  logic        nm_dirty
);

  typedef enum logic [2:0] {
    S_IDLE,   // waiting for a message word (in_ready high)
    S_START,  // nm_start pulse, operands already on nm_x/nm_r
    S_ARM,    // nmix raises dirty on the start edge; ignore it here
    S_BUSY,   // wait for dirty low or watchdog expiry
    S_FOLD,   // H <= H ^ Y, decide next word or tag
    S_OUT     // tag presented until tag_ready
  } state_t;

  // Last watchdog count value; the abort fires on the TIMEOUT-th BUSY cycle.
  localparam logic [9:0] CNT_LAST = 10'(TIMEOUT - 1);

  state_t      r_state;
  logic [31:0] r_h;          // chaining value
  logic        r_first;      // next accepted word starts a new message
  logic        r_last;       // word being processed is the final one
  logic [9:0]  r_cnt;        // BUSY watchdog
  logic [31:0] r_ybuf;       // captured nmix result
  logic [31:0] r_nm_x;
  logic [31:0] r_nm_r;
  logic        r_nm_start;
  logic        r_in_ready;
  logic        r_tag_valid;
  logic [31:0] r_tag;
  logic        r_tag_err;

  logic        w_accept;
  logic [31:0] w_h_init;
  logic [31:0] w_h_fold;
  logic        w_cnt_last;

  // Handshake, chaining-seed and fold arithmetic (XOR only, no carries).
  assign w_accept   = in_valid & r_in_ready;
  assign w_h_init   = IV ^ key;
  assign w_h_fold   = r_h ^ r_ybuf;
  assign w_cnt_last = (r_cnt == CNT_LAST);

  // Sequencer FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: all state uses non-blocking assignments so every register in this
    // block samples the pre-edge value of every other one, independent of the
    // order the statements are written in.
    if (!reset) begin
      r_state     <= S_IDLE;
      r_h         <= '0;
      r_first     <= 1'b1;
      r_last      <= 1'b0;
      r_cnt       <= '0;
      r_ybuf      <= '0;
      r_nm_x      <= '0;
      r_nm_r      <= '0;
      r_nm_start  <= 1'b0;
      r_in_ready  <= 1'b0;
      r_tag_valid <= 1'b0;
      r_tag       <= '0;
      r_tag_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            // Operands are latched here and stay put until the next accept,
            // because nmix reads them on every cycle of its run.
            r_nm_x     <= in_data;
            r_last     <= in_last;
            r_first    <= 1'b0;
            r_in_ready <= 1'b0;
            r_nm_start <= 1'b1;
            r_state    <= S_START;
            if (r_first) begin
              // Key is only ever sampled on the first word of a message.
              r_nm_r <= w_h_init;
              r_h    <= w_h_init;
            end else begin
              r_nm_r <= r_h;
            end
          end else begin
            // Also raises in_ready on the first cycle after reset release.
            r_in_ready <= 1'b1;
          end
        end

        S_START: begin
          r_nm_start <= 1'b0;
          r_cnt      <= '0;
          r_state    <= S_ARM;
        end

        S_ARM: begin
          r_state <= S_BUSY;
        end

        S_BUSY: begin
          r_cnt <= r_cnt + 10'd1;
          if (!nm_dirty) begin
            // Completion wins over a watchdog expiry in the same cycle.
            r_ybuf  <= nm_y;
            r_state <= S_FOLD;
          end else if (w_cnt_last) begin
            r_tag       <= '0;
            r_tag_err   <= 1'b1;
            r_first     <= 1'b1;
            r_cnt       <= '0;
            r_tag_valid <= 1'b1;
            r_state     <= S_OUT;
          end
        end

        S_FOLD: begin
          r_h <= w_h_fold;
          if (r_last) begin
            r_tag       <= w_h_fold;
            r_tag_err   <= 1'b0;
            r_first     <= 1'b1;
            r_tag_valid <= 1'b1;
            r_state     <= S_OUT;
          end else begin
            r_in_ready <= 1'b1;
            r_state    <= S_IDLE;
          end
        end

        S_OUT: begin
          // tag/tag_err are untouched here, so they hold under back-pressure.
          if (tag_ready) begin
            r_tag_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_nm_start  <= 1'b0;
          r_in_ready  <= 1'b0;
          r_tag_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  // Registered outputs.
  assign in_ready  = r_in_ready;
  assign tag_valid = r_tag_valid;
  assign tag       = r_tag;
  assign tag_err   = r_tag_err;
  assign nm_x      = r_nm_x;
  assign nm_r      = r_nm_r;
  assign nm_start  = r_nm_start;

endmodule

// File: tb/tb_nmix_mac_ctrl.sv
// tb_nmix_mac_ctrl -- self-checking bench for nmix_mac_ctrl. A behavioural
// nmix stand-in with programmable latency (or a stuck dirty flag) drives the
// nmix side; expected tags come from a message-level model H = IV ^ key,
// H ^= f(word, H) for each word.

module tb_nmix_mac_ctrl;

  localparam logic [31:0] TB_IV      = 32'h0000_0000;
  localparam int          TB_TIMEOUT = 1023;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [31:0] key;
  logic        tag_valid;
  logic        tag_ready;
  logic [31:0] tag;
  logic        tag_err;
  logic [31:0] nm_x;
  logic [31:0] nm_r;
  logic        nm_start;
  logic [31:0] nm_y     = '0;
  logic        nm_dirty = 1'b0;

  nmix_mac_ctrl #(
    .IV      (TB_IV),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .key       (key),
    .tag_valid (tag_valid),
    .tag_ready (tag_ready),
    .tag       (tag),
    .tag_err   (tag_err),
    .nm_x      (nm_x),
    .nm_r      (nm_r),
    .nm_start  (nm_start),
    .nm_y      (nm_y),
    .nm_dirty  (nm_dirty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in mixing function; f(x, 0) = x, so nmix(1,0)=1 and nmix(0,0)=0.
  function automatic logic [31:0] nmix_ref(input logic [31:0] x, input logic [31:0] r);
    logic [31:0] rot_r;
    logic [31:0] rot_x;
    rot_r = {r[24:0], r[31:25]};
    rot_x = {x[18:0], x[31:19]};
    return x ^ rot_r ^ (r & rot_x);
  endfunction

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // nmix stand-in: dirty rises on the start edge and stays high for
  // stub_lat cycles, then Y becomes f(X, R) of the operands held at that time.
  int stub_lat   = 1;
  bit stub_stuck = 1'b0;
  int stub_rem   = 0;

  always @(posedge clk) begin
    if (nm_start) begin
      nm_dirty <= 1'b1;
      stub_rem <= stub_lat - 1;
      nm_y     <= $urandom;
    end else if (nm_dirty && !stub_stuck) begin
      if (stub_rem == 0) begin
        nm_dirty <= 1'b0;
        nm_y     <= nmix_ref(nm_x, nm_r);
      end else begin
        stub_rem <= stub_rem - 1;
      end
    end
  end

  int start_pulses = 0;
  always @(posedge clk) begin
    if (nm_start) start_pulses <= start_pulses + 1;
  end

  logic [31:0] msg_w[$];

  // Offer one word, check the operands and the start pulse, then wait for
  // the controller to come back (in_ready or tag_valid) and check the delay.
  task automatic send_word(input logic [31:0] w, input logic lst, input logic [31:0] k,
                           input logic [31:0] exp_r, input int lat);
    int n;
    stub_lat = lat;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    in_last  = lst;
    key      = k;
    n = 0;
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
    in_last  = 1'($urandom);
    key      = $urandom;
    check("nm_start_pulse", 32'(nm_start), 32'd1);
    check("nm_x", nm_x, w);
    check("nm_r", nm_r, exp_r);
    @(negedge clk);
    check("nm_start_width", 32'(nm_start), 32'd0);
    n = 1;
    while (!in_ready && !tag_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("nm_r_hold", nm_r, exp_r);
    check("compute_latency", 32'(n), stub_stuck ? 32'(TB_TIMEOUT + 2) : 32'(lat + 3));
  endtask

  // Check a presented tag, hold it under back-pressure, then consume it.
  task automatic take_tag(input logic [31:0] exp_tag, input logic exp_err, input int hold);
    bit stable;
    check("tag_valid", 32'(tag_valid), 32'd1);
    check("tag", tag, exp_tag);
    check("tag_err", 32'(tag_err), 32'(exp_err));
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!tag_valid || tag !== exp_tag || tag_err !== exp_err || in_ready) stable = 1'b0;
    end
    check("tag_stable", 32'(stable), 32'd1);
    tag_ready = 1'b1;
    @(negedge clk);
    tag_ready = 1'b0;
    check("tag_drop", 32'(tag_valid), 32'd0);
    check("ready_after_tag", 32'(in_ready), 32'd1);
  endtask

  // Run every word of msg_w as one message and check the resulting tag.
  task automatic run_msg(input logic [31:0] k, input int hold);
    logic [31:0] h;
    int          p0;
    int          nw;
    h  = TB_IV ^ k;
    p0 = start_pulses;
    nw = msg_w.size();
    for (int i = 0; i < nw; i++) begin
      send_word(msg_w[i], (i == nw - 1), (i == 0) ? k : $urandom, h,
                int'($urandom_range(1, 24)));
      h = h ^ nmix_ref(msg_w[i], h);
      if (i != nw - 1) check("mid_no_tag", 32'(tag_valid), 32'd0);
    end
    check("start_count", 32'(start_pulses - p0), 32'(nw));
    take_tag(h, 1'b0, hold);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] k;
    logic [31:0] h;
    int          p0;
    int          n;
    bit          stale;

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    key       = '0;
    tag_ready = 1'b0;

    // Reset state
    repeat (5) @(negedge clk);
    check("rst_tag_valid", 32'(tag_valid), 32'd0);
    check("rst_nm_start", 32'(nm_start), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_tag", tag, 32'd0);
    check("rst_tag_err", 32'(tag_err), 32'd0);
    check("rst_nm_r", nm_r, 32'd0);
    check("rst_nm_x", nm_x, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // Single all-zero word
    msg_w = '{32'h0};
    run_msg(32'h0, 0);

    // Single words with known results
    msg_w = '{32'h1};
    run_msg(32'h0, 1);
    msg_w = '{32'h0};
    run_msg(32'h1, 1);

    // Two-word message
    msg_w = '{32'h1, 32'h2};
    run_msg(32'h0, 2);

    // Timeout on the second word of a message, then a fresh message
    k = 32'hA5C3_0F1E;
    h = TB_IV ^ k;
    send_word(32'h1234_5678, 1'b0, k, h, 5);
    h = h ^ nmix_ref(32'h1234_5678, h);
    check("to_no_tag", 32'(tag_valid), 32'd0);
    stub_stuck = 1'b1;
    send_word(32'h9ABC_DEF0, 1'b0, $urandom, h, 1);
    take_tag(32'h0, 1'b1, 2);
    stub_stuck = 1'b0;
    msg_w = '{32'hCAFE_F00D, 32'h0BAD_BEEF};
    run_msg(32'h1357_9BDF, 0);

    // Long back-pressure
    msg_w = '{$urandom};
    run_msg($urandom, 20);

    // Reset pulsed while BUSY
    stub_lat = 300;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = $urandom;
    in_last  = 1'b1;
    key      = $urandom;
    n = 0;
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_tag_valid", 32'(tag_valid), 32'd0);
    check("mid_rst_nm_start", 32'(nm_start), 32'd0);
    repeat (2) @(negedge clk);
    check("mid_rst_nm_r", nm_r, 32'd0);
    reset = 1'b1;
    p0    = start_pulses;
    stale = 1'b0;
    repeat (350) begin
      @(negedge clk);
      if (tag_valid) stale = 1'b1;
    end
    check("no_stale_tag", 32'(stale), 32'd0);
    check("no_restart", 32'(start_pulses - p0), 32'd0);
    check("post_rst_ready", 32'(in_ready), 32'd1);
    msg_w = '{32'h0F0F_0F0F, 32'hF0F0_F0F0};
    run_msg(32'h2468_ACE0, 1);

    // Randomized messages
    repeat (25) begin
      n = int'($urandom_range(1, 4));
      msg_w.delete();
      for (int i = 0; i < n; i++) msg_w.push_back($urandom);
      run_msg($urandom, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
